// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between a RISC-V core and a single-port word memory.
// Two-state FSM (IDLE/ACCESS). The memory request is launched combinationally
// from IDLE, held through ACCESS while the core keeps its inputs stable, and
// completed on mem_ready_i. Misaligned or illegal accesses are rejected in IDLE
// with a one-cycle err_o pulse, and a wait counter bounds ACCESS via TIMEOUT.
module riscv_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  // Counter wide enough to hold TIMEOUT itself; one bit when the timeout is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      size_q, size_d;

  // Legal = known funct3, natural alignment, and no unsigned-store encodings.
  function automatic logic access_legal(input logic we, input logic [2:0] size,
                                        input logic [1:0] off);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = ~off[0];
      3'd2:    ok = (off == 2'd0);
      3'd4:    ok = ~we;
      3'd5:    ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte lanes touched by a store; loads never assert lane enables.
  function automatic logic [3:0] store_be(input logic we, input logic [2:0] size,
                                          input logic [1:0] off);
    logic [3:0] be;
    if (we) begin
      case (size)
        3'd0:    be = 4'b0001 << off;
        3'd1:    be = 4'b0011 << off;
        3'd2:    be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end else begin
      be = 4'b0000;
    end
    return be;
  endfunction

  // Replicate right-aligned store data across every lane it could land in.
  function automatic logic [31:0] store_data(input logic [1:0] size_lo,
                                             input logic [31:0] wd);
    logic [31:0] d;
    case (size_lo)
      2'd0:    d = {4{wd[7:0]}};
      2'd1:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Pick the addressed byte/half out of the memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  size);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] r;
    case (off)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      3'd0:    r = {{24{byte_v[7]}}, byte_v};
      3'd4:    r = {24'd0, byte_v};
      3'd1:    r = {{16{half_v[15]}}, half_v};
      3'd5:    r = {16'd0, half_v};
      3'd2:    r = rdata;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // State, wait counter and captured access shape; reset clears everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      off_q   <= 2'd0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      size_q  <= size_d;
    end
  end

  // Next-state and output decode; reset forces every output low combinationally.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    size_d       = size_q;
    core_rd_o    = 32'd0;
    core_stall_o = 1'b0;
    err_o        = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'd0;
    mem_addr_o   = 32'd0;
    mem_wd_o     = 32'd0;
    if (rst_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      off_d   = 2'd0;
      size_d  = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (core_req_i) begin
            if (access_legal(core_we_i, core_size_i, core_addr_i[1:0])) begin
              mem_req_o    = 1'b1;
              mem_we_o     = core_we_i;
              mem_be_o     = store_be(core_we_i, core_size_i, core_addr_i[1:0]);
              mem_addr_o   = core_addr_i;
              mem_wd_o     = store_data(core_size_i[1:0], core_wd_i);
              core_stall_o = 1'b1;
              off_d        = core_addr_i[1:0];
              size_d       = core_size_i;
              cnt_d        = '0;
              state_d      = S_ACCESS;
            end else begin
              err_o   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ACCESS: begin
          // Core holds its inputs, so the memory side is re-derived from them.
          mem_req_o  = 1'b1;
          mem_we_o   = core_we_i;
          mem_be_o   = store_be(core_we_i, core_size_i, core_addr_i[1:0]);
          mem_addr_o = core_addr_i;
          mem_wd_o   = store_data(core_size_i[1:0], core_wd_i);
          if (mem_ready_i) begin
            core_rd_o = load_extract(mem_rd_i, off_q, size_q);
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT))) begin
            err_o   = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            core_stall_o = 1'b1;
            cnt_d        = (TIMEOUT != 0) ? (cnt_q + CW'(1)) : cnt_q;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum ACCESS cycles spent waiting for mem_ready_i; 0 disables the timeout.
REQ-002 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port core_req_i, input, 1: core requests a memory access.
REQ-005 SHALL have port core_we_i, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port core_size_i, input, 3: RISC-V funct3 encoding (0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU).
REQ-007 SHALL have port core_addr_i, input, 32: byte address.
REQ-008 SHALL have port core_wd_i, input, 32: store data, right-aligned.
REQ-009 SHALL have port core_rd_o, output, 32: load result after extension.
REQ-010 SHALL have port core_stall_o, output, 1: core holds all core_* inputs stable while this is 1.
REQ-011 SHALL have port err_o, output, 1: one-cycle pulse on misaligned access, illegal size or timeout.
REQ-012 SHALL have port mem_req_o, output, 1: memory request.
REQ-013 SHALL have port mem_we_o, output, 1: memory write enable.
REQ-014 SHALL have port mem_be_o, output, 4: byte lane enables.
REQ-015 SHALL have port mem_addr_o, output, 32: equals core_addr_i (memory indexes by addr[31:2]).
REQ-016 SHALL have port mem_wd_o, output, 32: lane-replicated store data.
REQ-017 SHALL have port mem_rd_i, input, 32: word read data, valid one cycle after the request with mem_req_o still high.
REQ-018 SHALL have port mem_ready_i, input, 1: memory completion.

Function
REQ-019 SHALL implement a two-state FSM: IDLE and ACCESS.
REQ-020 IDLE, legal core_req_i: SHALL drive mem_req_o=1 combinationally, assert core_stall_o=1, capture addr[1:0] and core_size_i into registers, and go to ACCESS.
REQ-021 ACCESS: SHALL hold mem_req_o=1 and the mem_* outputs derived from the held core inputs; when mem_ready_i=1, SHALL set core_stall_o=0 and core_rd_o=extracted mem_rd_i, and go to IDLE next edge.
REQ-022 ACCESS with mem_ready_i=0: SHALL keep core_stall_o=1 and increment the wait counter; when the counter reaches TIMEOUT (TIMEOUT != 0), SHALL pulse err_o, release the stall with core_rd_o=0, and go to IDLE.
REQ-023 Every legal access SHALL take at least 2 cycles (1 stall cycle); a back-to-back request SHALL restart from IDLE the cycle after completion.
REQ-024 Byte enables SHALL be: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<addr[1:0]; size 2 -> 4'b1111; mem_be_o SHALL be 0 on loads.
REQ-025 mem_wd_o SHALL be: SB {4{wd[7:0]}}; SH {2{wd[15:0]}}; SW wd.
REQ-026 Load extraction SHALL use the registered offset: LB/LBU select the byte at offset, then sign- or zero-extend; LH/LHU select the half at offset[1], then sign- or zero-extend; LW pass through.
REQ-027 Misalignment (half with addr[0]=1, word with addr[1:0]!=0) or size 3/6/7, or any store with size 4/5, SHALL produce: mem_req_o=0, no stall, err_o=1 that cycle, core_rd_o=0, FSM stays IDLE.
REQ-028 When not in a completing ACCESS cycle, core_rd_o SHALL be 0.
REQ-029 core_req_i=0 in IDLE SHALL produce all mem_* outputs 0 and core_stall_o=0.

Reset
REQ-030 Asserting rst_i SHALL force IDLE, clear the counter and the captured offset and size registers, and set every output to 0, including mid-ACCESS (the stall releases immediately).

Verification
REQ-031 LW at 0x10, mem_rd_i=0xDEADBEEF with ready=1 -> stall high 1 cycle, core_rd_o=0xDEADBEEF in cycle 2, be=0.
REQ-032 SB wd=0x000000A5 at 0x13 -> mem_be_o=4'b1000, mem_wd_o=0xA5A5A5A5, mem_we_o=1 for 2 cycles.
REQ-033 LB at 0x2 with mem_rd_i=0x00800000 -> 0xFFFFFF80; LBU -> 0x00000080; LH at 0x2 with 0x80010000 -> 0xFFFF8001.
REQ-034 LW at 0x6 -> err_o pulse, mem_req_o=0, stall 0; SH at 0x1 -> same.
REQ-035 TIMEOUT=4, ready held 0 -> stall for 4 ACCESS cycles, err_o pulse, core_rd_o=0, then IDLE.
REQ-036 rst_i asserted during ACCESS -> stall and mem_req_o drop asynchronously; the next request completes normally.
